// File: rtl/sata_traffic_pkg.sv
`default_nettype none
// ============================================================================
// sata_traffic_pkg : shared encodings for the SATA traffic generator/checker
// Rev 1.0
// ============================================================================
package sata_traffic_pkg;

  localparam logic [1:0]  MODE_INC   = 2'd0;
  localparam logic [1:0]  MODE_LFSR  = 2'd1;
  localparam logic [1:0]  MODE_FIXED = 2'd2;
  localparam logic [1:0]  MODE_WALK  = 2'd3;

  localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    GEN_IDLE    = 3'd0,
    GEN_GRAB    = 3'd1,
    GEN_WRITE   = 3'd2,
    GEN_RELEASE = 3'd3,
    GEN_DONE    = 3'd4
  } gen_state_t;

  typedef enum logic [2:0] {
    CHK_IDLE     = 3'd0,
    CHK_WAIT     = 3'd1,
    CHK_ACTIVATE = 3'd2,
    CHK_READ     = 3'd3,
    CHK_RELEASE  = 3'd4
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/sata_pattern_step.sv
`default_nettype none
// ============================================================================
// sata_pattern_step : first-word and next-word functions for the test patterns
// Rev 1.0
// ============================================================================
module sata_pattern_step
  import sata_traffic_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_POLY  = DEFAULT_LFSR_POLY
) (
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [DATA_WIDTH-1:0] o_first,
  output logic [DATA_WIDTH-1:0] o_next
);

  localparam logic [DATA_WIDTH-1:0] c_poly = DATA_WIDTH'(LFSR_POLY);

  // An all-zero LFSR state would lock up, so a zero seed starts at 1
  always_comb begin
    o_first = i_seed;
    if (i_mode == MODE_WALK || (i_mode == MODE_LFSR && i_seed == '0))
      o_first = DATA_WIDTH'(1);
  end

  always_comb begin
    o_next = i_word;
    case (i_mode)
      MODE_INC:  o_next = i_word + DATA_WIDTH'(1);
      MODE_LFSR: o_next = (i_word >> 1) ^ (i_word[0] ? c_poly : '0);
      MODE_WALK: o_next = {i_word[DATA_WIDTH-2:0], i_word[DATA_WIDTH-1]};
      default:   o_next = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sata_traffic_gen_chk.sv
`default_nettype none
// ============================================================================
// sata_traffic_gen_chk : pattern source into the H2D ping-pong FIFO and
// pattern checker on the D2H FIFO.  Rev 1.0
// ============================================================================
module sata_traffic_gen_chk
  import sata_traffic_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          COUNT_WIDTH = 24,
  parameter logic [31:0] LFSR_POLY   = DEFAULT_LFSR_POLY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_mode,
  input  logic [DATA_WIDTH-1:0]  i_seed,
  input  logic                   i_gen_enable,
  input  logic [COUNT_WIDTH-1:0] i_gen_count,
  output logic                   o_gen_finished,
  input  logic [1:0]             i_wr_ready,
  output logic [1:0]             o_wr_activate,
  input  logic [COUNT_WIDTH-1:0] i_wr_size,
  output logic [DATA_WIDTH-1:0]  o_wr_data,
  output logic                   o_wr_stb,
  input  logic                   i_chk_enable,
  input  logic                   i_rd_ready,
  output logic                   o_rd_activate,
  input  logic [COUNT_WIDTH-1:0] i_rd_size,
  input  logic [DATA_WIDTH-1:0]  i_rd_data,
  output logic                   o_rd_stb,
  output logic                   o_chk_busy,
  output logic                   o_chk_error,
  output logic [15:0]            o_chk_error_count,
  output logic [COUNT_WIDTH-1:0] o_chk_total,
  output logic [COUNT_WIDTH-1:0] o_chk_first_err
);

  gen_state_t             r_gst;
  logic                   r_gen_en_d;
  logic [1:0]             r_gmode;
  logic [DATA_WIDTH-1:0]  r_gword;
  logic [COUNT_WIDTH-1:0] r_remaining, r_burst, r_gcnt;
  logic                   r_gen_finished, r_wr_stb;
  logic [1:0]             r_wr_activate;
  logic [DATA_WIDTH-1:0]  r_wr_data;

  chk_state_t             r_cst;
  logic                   r_chk_en_d;
  logic [1:0]             r_cmode;
  logic [DATA_WIDTH-1:0]  r_exp;
  logic [COUNT_WIDTH-1:0] r_rsize, r_ccnt;
  logic                   r_rd_activate, r_rd_stb, r_chk_error;
  logic [15:0]            r_err_count;
  logic [COUNT_WIDTH-1:0] r_chk_total, r_first_err;

  logic [1:0]             w_gmode, w_cmode;
  logic [DATA_WIDTH-1:0]  w_gfirst, w_gnext, w_cfirst, w_cnext;
  logic [COUNT_WIDTH-1:0] w_burst;
  logic                   w_gen_rise, w_chk_rise;

  // Mode is taken live while idle (to build the first word) and latched after
  assign w_gmode    = (r_gst == GEN_IDLE) ? i_mode : r_gmode;
  assign w_cmode    = (r_cst == CHK_IDLE) ? i_mode : r_cmode;
  assign w_gen_rise = i_gen_enable & ~r_gen_en_d;
  assign w_chk_rise = i_chk_enable & ~r_chk_en_d;
  assign w_burst    = (i_wr_size < r_remaining) ? i_wr_size : r_remaining;

  sata_pattern_step #(.DATA_WIDTH(DATA_WIDTH), .LFSR_POLY(LFSR_POLY)) u_gen_step (
    .i_mode (w_gmode),
    .i_seed (i_seed),
    .i_word (r_gword),
    .o_first(w_gfirst),
    .o_next (w_gnext)
  );

  sata_pattern_step #(.DATA_WIDTH(DATA_WIDTH), .LFSR_POLY(LFSR_POLY)) u_chk_step (
    .i_mode (w_cmode),
    .i_seed (i_seed),
    .i_word (r_exp),
    .o_first(w_cfirst),
    .o_next (w_cnext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gst          <= GEN_IDLE;
      r_gen_en_d     <= 1'b0;
      r_gmode        <= MODE_INC;
      r_gword        <= '0;
      r_remaining    <= '0;
      r_burst        <= '0;
      r_gcnt         <= '0;
      r_gen_finished <= 1'b0;
      r_wr_stb       <= 1'b0;
      r_wr_activate  <= 2'b00;
      r_wr_data      <= '0;
    end else begin
      r_gen_en_d <= i_gen_enable;
      case (r_gst)
        GEN_IDLE: if (w_gen_rise) begin
          r_gmode     <= i_mode;
          r_gword     <= w_gfirst;
          r_remaining <= i_gen_count;
          if (i_gen_count == '0) begin
            r_gen_finished <= 1'b1;
            r_gst          <= GEN_DONE;
          end else begin
            r_gst <= GEN_GRAB;
          end
        end
        GEN_GRAB: if (|i_wr_ready) begin
          r_wr_activate <= i_wr_ready[0] ? 2'b01 : 2'b10;
          r_burst       <= w_burst;
          r_gcnt        <= '0;
          r_gst         <= GEN_WRITE;
        end
        GEN_WRITE: if (r_gcnt != r_burst) begin
          r_wr_stb    <= 1'b1;
          r_wr_data   <= r_gword;
          r_gword     <= w_gnext;
          r_gcnt      <= r_gcnt + COUNT_WIDTH'(1);
          r_remaining <= r_remaining - COUNT_WIDTH'(1);
        end else begin
          r_wr_stb      <= 1'b0;
          r_wr_activate <= 2'b00;
          r_gst         <= GEN_RELEASE;
        end
        GEN_RELEASE: if (r_remaining != '0) begin
          r_gst <= GEN_GRAB;
        end else begin
          r_gen_finished <= 1'b1;
          r_gst          <= GEN_DONE;
        end
        GEN_DONE: if (!i_gen_enable) begin
          r_gen_finished <= 1'b0;
          r_gst          <= GEN_IDLE;
        end
        default: r_gst <= GEN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cst         <= CHK_IDLE;
      r_chk_en_d    <= 1'b0;
      r_cmode       <= MODE_INC;
      r_exp         <= '0;
      r_rsize       <= '0;
      r_ccnt        <= '0;
      r_rd_activate <= 1'b0;
      r_rd_stb      <= 1'b0;
      r_chk_error   <= 1'b0;
      r_err_count   <= '0;
      r_chk_total   <= '0;
      r_first_err   <= '0;
    end else begin
      r_chk_en_d <= i_chk_enable;
      case (r_cst)
        CHK_IDLE: if (w_chk_rise) begin
          r_cmode     <= i_mode;
          r_exp       <= w_cfirst;
          r_chk_error <= 1'b0;
          r_err_count <= '0;
          r_chk_total <= '0;
          r_first_err <= '0;
          r_cst       <= CHK_WAIT;
        end
        CHK_WAIT: if (!i_chk_enable) begin
          r_cst <= CHK_IDLE;
        end else if (i_rd_ready) begin
          r_rd_activate <= 1'b1;
          r_cst         <= CHK_ACTIVATE;
        end
        CHK_ACTIVATE: begin
          r_rsize <= i_rd_size;
          if (i_rd_size == '0) begin
            r_rd_activate <= 1'b0;
            r_cst         <= CHK_RELEASE;
          end else begin
            r_rd_stb <= 1'b1;
            r_ccnt   <= COUNT_WIDTH'(1);
            r_cst    <= CHK_READ;
          end
        end
        // Strobe is high for every cycle spent here; r_ccnt counts strobes issued
        CHK_READ: begin
          if (i_rd_data != r_exp) begin
            r_chk_error <= 1'b1;
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (!r_chk_error) r_first_err <= r_chk_total;
          end
          r_exp       <= w_cnext;
          r_chk_total <= r_chk_total + COUNT_WIDTH'(1);
          if (r_ccnt != r_rsize) begin
            r_ccnt <= r_ccnt + COUNT_WIDTH'(1);
          end else begin
            r_rd_stb      <= 1'b0;
            r_rd_activate <= 1'b0;
            r_cst         <= CHK_RELEASE;
          end
        end
        CHK_RELEASE: r_cst <= CHK_WAIT;
        default:     r_cst <= CHK_IDLE;
      endcase
    end
  end

  assign o_gen_finished    = r_gen_finished;
  assign o_wr_activate     = r_wr_activate;
  assign o_wr_data         = r_wr_data;
  assign o_wr_stb          = r_wr_stb;
  assign o_rd_activate     = r_rd_activate;
  assign o_rd_stb          = r_rd_stb;
  assign o_chk_busy        = r_rd_activate;
  assign o_chk_error       = r_chk_error;
  assign o_chk_error_count = r_err_count;
  assign o_chk_total       = r_chk_total;
  assign o_chk_first_err   = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_sata_traffic_gen_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sata_traffic_gen_chk : scoreboard bench with ping-pong FIFO models
// Rev 1.0
// ============================================================================
module tb_sata_traffic_gen_chk;
  localparam int DW    = 32;
  localparam int CW    = 24;
  localparam int DRAIN = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] seed = '0;
  logic          gen_enable = 1'b0, chk_enable = 1'b0;
  logic [CW-1:0] gen_count = '0, wr_size = '0;
  logic [1:0]    wr_ready = 2'b00;
  logic          rd_ready = 1'b0;
  logic [CW-1:0] rd_size = '0;
  logic [DW-1:0] rd_data = '0;
  logic          gen_finished, wr_stb, rd_activate, rd_stb, chk_busy, chk_error;
  logic [1:0]    wr_activate;
  logic [DW-1:0] wr_data;
  logic [15:0]   chk_error_count;
  logic [CW-1:0] chk_total, chk_first_err;

  always #5 clk = ~clk;

  sata_traffic_gen_chk #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_seed(seed),
    .i_gen_enable(gen_enable), .i_gen_count(gen_count), .o_gen_finished(gen_finished),
    .i_wr_ready(wr_ready), .o_wr_activate(wr_activate), .i_wr_size(wr_size),
    .o_wr_data(wr_data), .o_wr_stb(wr_stb),
    .i_chk_enable(chk_enable), .i_rd_ready(rd_ready), .o_rd_activate(rd_activate),
    .i_rd_size(rd_size), .i_rd_data(rd_data), .o_rd_stb(rd_stb),
    .o_chk_busy(chk_busy), .o_chk_error(chk_error), .o_chk_error_count(chk_error_count),
    .o_chk_total(chk_total), .o_chk_first_err(chk_first_err)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_first(input logic [1:0] md, input logic [DW-1:0] sd);
    if (md == 2'd3) return 32'd1;
    if (md == 2'd1 && sd == 0) return 32'd1;
    return sd;
  endfunction

  function automatic logic [DW-1:0] m_next(input logic [1:0] md, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    case (md)
      2'd0: r = w + 32'd1;
      2'd1: begin r = {1'b0, w[DW-1:1]}; if (w[0]) r = r ^ 32'h8020_0003; end
      2'd3: r = (w << 1) | (w >> (DW-1));
      default: r = w;
    endcase
    return r;
  endfunction

  // Scoreboard and both FIFO models live in one process
  logic [DW-1:0] gen_exp[$], rdq[$], gen_words[$];
  int            claim_buf[$], claim_len[$];
  int            cur_len = 0, pop_idx = 0, blk_left = 0;
  int            busy[2] = '{0, 0};
  logic [1:0]    act_prev = 2'b00;
  logic          pend_pop = 1'b0;
  logic          clr_req = 1'b0;
  logic [1:0]    req_mode = 2'd0;
  logic [DW-1:0] req_seed = '0;
  int            req_n = 0;
  int            inj_a = -1, inj_b = -1;

  always @(negedge clk) begin : models
    logic [DW-1:0] w;
    if (clr_req) begin
      gen_exp.delete(); rdq.delete(); gen_words.delete();
      claim_buf.delete(); claim_len.delete();
      cur_len = 0; pop_idx = 0; blk_left = 0; pend_pop = 1'b0;
      busy[0] = 0; busy[1] = 0;
      rd_ready = 1'b0; rd_size = '0; rd_data = '0;
      w = m_first(req_mode, req_seed);
      for (int i = 0; i < req_n; i++) begin
        gen_exp.push_back(w);
        w = m_next(req_mode, w);
      end
    end else begin
      if (wr_stb) begin
        if (gen_exp.size() == 0) check("gen_unexpected_word", gen_exp.size(), 1);
        else check("gen_word", wr_data, gen_exp.pop_front());
        gen_words.push_back(wr_data);
        rdq.push_back(wr_data);
        cur_len++;
      end
      if (pend_pop) begin
        void'(rdq.pop_front());
        pop_idx++;
        blk_left--;
      end
      pend_pop = rd_stb;
      if (rd_activate) rd_ready = 1'b0;
      else if (!rd_ready && blk_left == 0 && rdq.size() > 0) begin
        blk_left = (rdq.size() > 64) ? 64 : rdq.size();
        rd_size  = CW'(blk_left);
        rd_ready = 1'b1;
      end
      rd_data = (rdq.size() > 0) ? rdq[0] : '0;
      if (pop_idx == inj_a || pop_idx == inj_b) rd_data[0] = ~rd_data[0];
    end
    for (int i = 0; i < 2; i++) begin
      if (act_prev[i] && !wr_activate[i]) begin
        claim_buf.push_back(i);
        claim_len.push_back(cur_len);
        cur_len = 0;
        busy[i] = DRAIN;
      end else if (busy[i] > 0) begin
        busy[i]--;
      end
      wr_ready[i] = (busy[i] == 0) && !wr_activate[i];
    end
    act_prev = wr_activate;
  end

  task automatic start_run(input logic [1:0] md, input logic [DW-1:0] sd, input int n,
                           input int wsize, input bit with_chk);
    @(negedge clk);
    gen_enable = 1'b0; chk_enable = 1'b0;
    repeat (4) @(negedge clk);
    req_mode = md; req_seed = sd; req_n = n; clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    @(negedge clk);
    mode = md; seed = sd; gen_count = CW'(n); wr_size = CW'(wsize);
    gen_enable = 1'b1; chk_enable = with_chk;
  endtask

  task automatic finish_run(input int n, input bit with_chk);
    bit done = 1'b0;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      done = gen_finished && (!with_chk || (chk_total == CW'(n) && !rd_activate));
    end
    check("run_completed", done, 1);
    check("gen_all_words_sent", gen_exp.size(), 0);
  endtask

  initial begin : stim
    int ebuf[4] = '{0, 1, 0, 1};
    int elen[4] = '{256, 256, 256, 232};
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_activate", wr_activate, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_gen_finished", gen_finished, 0);
    check("rst_rd_activate", rd_activate, 0);
    check("rst_rd_stb", rd_stb, 0);
    check("rst_chk_busy", chk_busy, 0);
    check("rst_chk_error", chk_error, 0);
    check("rst_err_count", chk_error_count, 0);
    check("rst_chk_total", chk_total, 0);
    check("rst_first_err", chk_first_err, 0);
    @(negedge clk) rst_n = 1'b1;

    // Ping-pong arbitration over a 1000-word incrementing transfer
    start_run(2'd0, 32'd0, 1000, 256, 1'b1);
    finish_run(1000, 1'b1);
    check("t1_gen_finished", gen_finished, 1);
    check("t1_claims", claim_buf.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < claim_buf.size()) begin
        check($sformatf("t1_claim%0d_buf", i), claim_buf[i], ebuf[i]);
        check($sformatf("t1_claim%0d_len", i), claim_len[i], elen[i]);
      end
    end
    if (gen_words.size() == 1000) check("t1_last_word", gen_words[999], 999);
    else check("t1_word_count", gen_words.size(), 1000);
    check("t1_chk_error", chk_error, 0);
    check("t1_chk_total", chk_total, 1000);

    // Loopback in every mode
    for (int m = 0; m < 4; m++) begin
      start_run(m[1:0], 32'h1234_5678, 4096, 256, 1'b1);
      finish_run(4096, 1'b1);
      check($sformatf("lb%0d_chk_error", m), chk_error, 0);
      check($sformatf("lb%0d_err_count", m), chk_error_count, 0);
      check($sformatf("lb%0d_chk_total", m), chk_total, 4096);
      check($sformatf("lb%0d_first_err", m), chk_first_err, 0);
    end

    // Corrupted read words 17 and 300
    inj_a = 17; inj_b = 300;
    start_run(2'd0, 32'h1234_5678, 512, 256, 1'b1);
    finish_run(512, 1'b1);
    check("inj_chk_error", chk_error, 1);
    check("inj_err_count", chk_error_count, 2);
    check("inj_first_err", chk_first_err, 17);
    check("inj_chk_total", chk_total, 512);
    inj_a = -1; inj_b = -1;

    // Zero-length transfer
    start_run(2'd0, 32'd0, 0, 256, 1'b0);
    #1 check("cnt0_finished_before_edge", gen_finished, 0);
    @(negedge clk);
    check("cnt0_finished", gen_finished, 1);
    check("cnt0_no_activate", wr_activate, 0);
    repeat (3) @(negedge clk);
    check("cnt0_no_claims", claim_buf.size(), 0);

    // LFSR from a zero seed
    start_run(2'd1, 32'd0, 8, 256, 1'b1);
    finish_run(8, 1'b1);
    if (gen_words.size() >= 2) begin
      check("lfsr0_word0", gen_words[0], 32'h1);
      check("lfsr0_word1", gen_words[1], 32'h8020_0003);
    end else check("lfsr0_word_count", gen_words.size(), 8);

    // Walking one wraps after DW words
    start_run(2'd3, 32'hDEAD_BEEF, 40, 256, 1'b1);
    finish_run(40, 1'b1);
    if (gen_words.size() >= 33) begin
      check("walk_word31", gen_words[31], 32'h8000_0000);
      check("walk_word32", gen_words[32], 32'h1);
    end else check("walk_word_count", gen_words.size(), 40);
    check("walk_chk_error", chk_error, 0);

    // Asynchronous reset in the middle of a write burst
    start_run(2'd0, 32'h100, 600, 256, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      seen = (gen_words.size() >= 50);
    end
    check("rstmid_reached_write", seen, 1);
    check("rstmid_pre_activate", wr_activate, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_activate", wr_activate, 0);
    check("rstmid_stb", wr_stb, 0);
    gen_enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    start_run(2'd0, 32'h100, 300, 256, 1'b1);
    finish_run(300, 1'b1);
    if (gen_words.size() > 0) check("rstmid_restart_word0", gen_words[0], 32'h100);
    else check("rstmid_restart_count", gen_words.size(), 300);
    check("rstmid_chk_total", chk_total, 300);
    check("rstmid_chk_error", chk_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
